// File: rtl/flag_branch_unit_pkg.sv
// Shared types and constants for the NZCV flag register and branch resolver.
package flag_branch_unit_pkg;

   // Branch kinds presented to the resolver
   typedef enum logic [1:0] {
      BR_COND   = 2'd0,
      BR_CBZ    = 2'd1,
      BR_CBNZ   = 2'd2,
      BR_UNCOND = 2'd3
   } br_type_e;

   // AArch64 condition codes
   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Bit positions inside the {N,Z,C,V} vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Interface bundling the EX-stage, branch and result signals of flag_branch_unit.
interface flag_branch_unit_if #(
   parameter int CNT_W = 16
) ();
   logic             stall;
   logic             flush;
   logic             ex_valid;
   logic             ex_set_flags;
   logic             ex_neg;
   logic             ex_zero;
   logic             ex_carry;
   logic             ex_overflow;
   logic             br_valid;
   logic [1:0]       br_type;
   logic [3:0]       br_cond;
   logic             cbz_zero;
   logic [3:0]       flags_q;
   logic             br_resolved_q;
   logic             br_taken_q;
   logic [CNT_W-1:0] taken_cnt_q;

   // Pipeline side: drives instructions, observes results
   modport master (
      output stall, flush, ex_valid, ex_set_flags, ex_neg, ex_zero, ex_carry,
             ex_overflow, br_valid, br_type, br_cond, cbz_zero,
      input  flags_q, br_resolved_q, br_taken_q, taken_cnt_q
   );

   // Flag/branch unit side
   modport slave (
      input  stall, flush, ex_valid, ex_set_flags, ex_neg, ex_zero, ex_carry,
             ex_overflow, br_valid, br_type, br_cond, cbz_zero,
      output flags_q, br_resolved_q, br_taken_q, taken_cnt_q
   );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational AArch64 condition-code evaluator over an NZCV vector.
module flag_branch_unit_cond_eval
   import flag_branch_unit_pkg::*;
(
   input  cond_e      cond,
   input  logic [3:0] nzcv,
   output logic       cond_true
);
   logic n_s;
   logic z_s;
   logic c_s;
   logic v_s;

   assign n_s = nzcv[FLAG_N];
   assign z_s = nzcv[FLAG_Z];
   assign c_s = nzcv[FLAG_C];
   assign v_s = nzcv[FLAG_V];

   // Decode the condition; NV is always-true in AArch64
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_EQ: cond_true = z_s;
         COND_NE: cond_true = ~z_s;
         COND_CS: cond_true = c_s;
         COND_CC: cond_true = ~c_s;
         COND_MI: cond_true = n_s;
         COND_PL: cond_true = ~n_s;
         COND_VS: cond_true = v_s;
         COND_VC: cond_true = ~v_s;
         COND_HI: cond_true = c_s & ~z_s;
         COND_LS: cond_true = ~(c_s & ~z_s);
         COND_GE: cond_true = (n_s == v_s);
         COND_LT: cond_true = (n_s != v_s);
         COND_GT: cond_true = ~z_s & (n_s == v_s);
         COND_LE: cond_true = ~(~z_s & (n_s == v_s));
         COND_AL: cond_true = 1'b1;
         COND_NV: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end
endmodule

// File: rtl/flag_branch_unit.sv
// Architectural NZCV register with same-cycle flag bypass, registered branch
// resolution and a saturating taken-branch counter.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset,
   flag_branch_unit_if.slave bus
);
   logic [3:0]       flags_q;
   logic [3:0]       flags_d;
   logic             br_resolved_q;
   logic             br_resolved_d;
   logic             br_taken_q;
   logic             br_taken_d;
   logic [CNT_W-1:0] taken_cnt_q;
   logic [CNT_W-1:0] taken_cnt_d;

   logic             ex_upd_s;
   logic             resolve_s;
   logic [3:0]       ex_flags_s;
   logic [3:0]       f_eff_s;
   logic             cond_true_s;
   logic             taken_s;

   assign ex_flags_s = {bus.ex_neg, bus.ex_zero, bus.ex_carry, bus.ex_overflow};

   // Qualify the flag write and branch resolution with stall/flush
   always_comb begin
      ex_upd_s  = bus.ex_valid & bus.ex_set_flags & ~bus.stall & ~bus.flush;
      resolve_s = bus.br_valid & ~bus.stall & ~bus.flush;
   end

   // Bypass: a younger branch sees the flags being written this cycle
   always_comb begin
      if (ex_upd_s) begin
         f_eff_s = ex_flags_s;
      end else begin
         f_eff_s = flags_q;
      end
   end

   flag_branch_unit_cond_eval u_cond_eval (
      .cond      (cond_e'(bus.br_cond)),
      .nzcv      (f_eff_s),
      .cond_true (cond_true_s)
   );

   // Select the taken decision by branch kind; CBZ/CBNZ ignore flags
   always_comb begin
      taken_s = 1'b0;
      case (br_type_e'(bus.br_type))
         BR_COND:   taken_s = cond_true_s;
         BR_CBZ:    taken_s = bus.cbz_zero;
         BR_CBNZ:   taken_s = ~bus.cbz_zero;
         BR_UNCOND: taken_s = 1'b1;
         default:   taken_s = 1'b0;
      endcase
   end

   // Next-state for flags, resolution pulse and saturating counter
   always_comb begin
      flags_d       = flags_q;
      taken_cnt_d   = taken_cnt_q;
      br_resolved_d = resolve_s;
      br_taken_d    = resolve_s & taken_s;
      if (ex_upd_s) begin
         flags_d = ex_flags_s;
      end else begin
         flags_d = flags_q;
      end
      if (resolve_s && taken_s && !(&taken_cnt_q)) begin
         taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         taken_cnt_d = taken_cnt_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q       <= 4'b0000;
         br_resolved_q <= 1'b0;
         br_taken_q    <= 1'b0;
         taken_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         flags_q       <= flags_d;
         br_resolved_q <= br_resolved_d;
         br_taken_q    <= br_taken_d;
         taken_cnt_q   <= taken_cnt_d;
      end
   end

   assign bus.flags_q       = flags_q;
   assign bus.br_resolved_q = br_resolved_q;
   assign bus.br_taken_q    = br_taken_q;
   assign bus.taken_cnt_q   = taken_cnt_q;
endmodule
